// File: rtl/conv_pkg.sv
// Package: conv_pkg
// Shared helpers for the streaming convolution engine.
//   wide_t       - 64-bit signed scratch type used for post-sum scaling/clipping
//   acc_width    - accumulator width that cannot overflow for a K x K window of W-bit products
//   kernel_index - flat coefficient index for window position (r, c)
//   sat_clip     - saturate a wide signed value to the range of a signed w-bit word
package conv_pkg;

    typedef logic signed [63:0] wide_t;

    function automatic int acc_width(input int w, input int k);
        return 2 * w + $clog2(k * k);
    endfunction

    function automatic int kernel_index(input int r, input int c, input int k);
        return r * k + c;
    endfunction

    function automatic wide_t sat_clip(input wide_t value, input int w);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        lo = -hi - wide_t'(1);
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/conv_stream_if.sv
// Interface: conv_stream_if
// Bundles the kernel-load port, the pixel input stream and the result stream.
//   k_we/k_addr/k_data     - coefficient write (index r*K+c)
//   in_valid/in_sof/in_data - raster-order pixel stream, in_sof marks first pixel of a frame
//   out_valid/out_data      - clipped convolution results
// Modports: master drives kernel/pixels and observes results; slave is the engine.
interface conv_stream_if #(
    parameter int KERNEL_SIZE = 3,
    parameter int WORD_SIZE   = 16
) ();
    localparam int ADDR_W = $clog2(KERNEL_SIZE * KERNEL_SIZE);

    logic                        k_we;
    logic [ADDR_W-1:0]           k_addr;
    logic signed [WORD_SIZE-1:0] k_data;
    logic                        in_valid;
    logic                        in_sof;
    logic signed [WORD_SIZE-1:0] in_data;
    logic                        out_valid;
    logic signed [WORD_SIZE-1:0] out_data;

    modport master (
        output k_we, k_addr, k_data, in_valid, in_sof, in_data,
        input  out_valid, out_data
    );

    modport slave (
        input  k_we, k_addr, k_data, in_valid, in_sof, in_data,
        output out_valid, out_data
    );

endinterface

// File: rtl/conv_line_buffer.sv
// Module: conv_line_buffer
// One image line of delay: dout is the word written DEPTH enabled cycles ago.
// A single wrap-around pointer serves as both read and write address, so the
// read happens before the overwrite at the same location. Storage is never
// cleared; the engine's row/col counters mask stale contents.
//   clk, reset_n - clock, asynchronous active-low reset (pointer only)
//   en           - advance (one accepted pixel)
//   din / dout   - pixel in / pixel from one line earlier
module conv_line_buffer #(
    parameter int DEPTH     = 640,
    parameter int WORD_SIZE = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        en,
    input  logic signed [WORD_SIZE-1:0] din,
    output logic signed [WORD_SIZE-1:0] dout
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic signed [WORD_SIZE-1:0] mem [DEPTH];
    logic [PTR_W-1:0]            ptr;

    assign dout = mem[ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
        end
    end

    // Storage has no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr] <= din;
        end
    end

endmodule

// File: rtl/conv_stream.sv
// Module: conv_stream
// Streaming K x K "valid" convolution over raster-order pixels.
// Stages: E0 window update, E1 products, E2 per-row sums, E3 scale/clip/output.
//   clk, reset_n - clock, asynchronous active-low reset
//   bus (slave)  - kernel write port, pixel input stream, result output stream
module conv_stream
    import conv_pkg::*;
#(
    parameter int KERNEL_SIZE = 3,
    parameter int WORD_SIZE   = 16,
    parameter int IMG_WIDTH   = 640,
    parameter int FRAC_BITS   = 0
) (
    input  logic          clk,
    input  logic          reset_n,
    conv_stream_if.slave  bus
);
    localparam int K  = KERNEL_SIZE;
    localparam int W  = WORD_SIZE;
    localparam int KK = K * K;
    localparam int PW = 2 * W;
    localparam int AW = acc_width(W, K);
    localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int RW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(K - 1);

    logic [CW-1:0]         col;
    logic [CW-1:0]         pos_col;
    logic [RW-1:0]         row;
    logic [RW-1:0]         pos_row;
    logic                  out_pos;
    logic signed [W-1:0]   kern [KK];
    logic signed [W-1:0]   win [K][K];
    logic signed [W-1:0]   lb_out [K-1];
    logic signed [PW-1:0]  prod [K][K];
    logic signed [AW-1:0]  row_sum [K];
    logic signed [AW-1:0]  row_sum_next [K];
    logic signed [AW-1:0]  total;
    wide_t                 shifted;
    logic                  valid0;
    logic                  valid1;
    logic                  valid2;

    // Position of the pixel being presented; in_sof restarts the frame at (0,0).
    // Only the bottom-right corner of a fully populated window yields a result.
    always_comb begin
        pos_col = bus.in_sof ? '0 : col;
        pos_row = bus.in_sof ? '0 : row;
        out_pos = (pos_row == ROW_LAST) && (pos_col >= COL_FIRST);
    end

    // Row saturates at K-1: beyond that every line is equally usable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col <= '0;
            row <= '0;
        end else if (bus.in_valid) begin
            if (pos_col == COL_LAST) begin
                col <= '0;
                row <= (pos_row == ROW_LAST) ? pos_row : pos_row + 1'b1;
            end else begin
                col <= pos_col + 1'b1;
                row <= pos_row;
            end
        end
    end

    // Line buffers are chained so buffer i delays by i+1 lines.
    for (genvar i = 0; i < K - 1; i++) begin : g_lb
        logic signed [W-1:0] lb_in;
        if (i == 0) begin : g_first
            assign lb_in = bus.in_data;
        end else begin : g_next
            assign lb_in = lb_out[i-1];
        end
        conv_line_buffer #(
            .DEPTH     (IMG_WIDTH),
            .WORD_SIZE (W)
        ) u_lb (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (bus.in_valid),
            .din     (lb_in),
            .dout    (lb_out[i])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < KK; i++) begin
                kern[i] <= '0;
            end
        end else if (bus.k_we) begin
            kern[bus.k_addr] <= bus.k_data;
        end
    end

    // E0: shift window left; new right column comes from the line buffers
    // (oldest line at row 0) with the live pixel at the bottom.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win[r][c] <= '0;
                end
            end
            valid0 <= 1'b0;
        end else begin
            valid0 <= bus.in_valid && out_pos;
            if (bus.in_valid) begin
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K - 1; c++) begin
                        win[r][c] <= win[r][c+1];
                    end
                end
                for (int r = 0; r < K - 1; r++) begin
                    win[r][K-1] <= lb_out[K-2-r];
                end
                win[K-1][K-1] <= bus.in_data;
            end
        end
    end

    // E1: products. A coefficient written on this same edge is not yet seen.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    prod[r][c] <= '0;
                end
            end
            valid1 <= 1'b0;
        end else begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    prod[r][c] <= PW'(win[r][c]) * PW'(kern[kernel_index(r, c, K)]);
                end
            end
            valid1 <= valid0;
        end
    end

    always_comb begin
        for (int r = 0; r < K; r++) begin
            row_sum_next[r] = '0;
            for (int c = 0; c < K; c++) begin
                row_sum_next[r] = row_sum_next[r] + AW'(prod[r][c]);
            end
        end
    end

    // E2: per-row sums
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < K; r++) begin
                row_sum[r] <= '0;
            end
            valid2 <= 1'b0;
        end else begin
            for (int r = 0; r < K; r++) begin
                row_sum[r] <= row_sum_next[r];
            end
            valid2 <= valid1;
        end
    end

    always_comb begin
        total = '0;
        for (int r = 0; r < K; r++) begin
            total = total + row_sum[r];
        end
        shifted = wide_t'(total) >>> FRAC_BITS;
    end

    // E3: scale, clip, present. out_data holds its last result between outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
        end else begin
            bus.out_valid <= valid2;
            if (valid2) begin
                bus.out_data <= W'(sat_clip(shifted, W));
            end
        end
    end

endmodule

// File: tb/tb_conv_stream.sv
// Testbench: tb_conv_stream
// Drives two engines (FRAC_BITS 0 and 2) with identical stimulus and checks
// both result streams against a frame-array reference model.
module tb_conv_stream;

    localparam int K   = 3;
    localparam int W   = 8;
    localparam int IMG = 5;
    localparam int KK  = K * K;

    typedef struct {
        int v0;
        int v2;
        bit ok2;
        int cyc;
    } got_t;

    typedef struct {
        int e0;
        int e2;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    int   cycle = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   p12_edge = 0;
    int   kern_m [KK];
    int   frame_q [$];
    got_t got_q [$];
    exp_t exp_q [$];

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    conv_stream_if #(.KERNEL_SIZE(K), .WORD_SIZE(W)) bus0 ();
    conv_stream_if #(.KERNEL_SIZE(K), .WORD_SIZE(W)) bus2 ();

    assign bus2.k_we     = bus0.k_we;
    assign bus2.k_addr   = bus0.k_addr;
    assign bus2.k_data   = bus0.k_data;
    assign bus2.in_valid = bus0.in_valid;
    assign bus2.in_sof   = bus0.in_sof;
    assign bus2.in_data  = bus0.in_data;

    conv_stream #(.KERNEL_SIZE(K), .WORD_SIZE(W), .IMG_WIDTH(IMG), .FRAC_BITS(0)) dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0)
    );

    conv_stream #(.KERNEL_SIZE(K), .WORD_SIZE(W), .IMG_WIDTH(IMG), .FRAC_BITS(2)) dut2 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus2)
    );

    // Capture every result of the reference engine together with its twin.
    always @(negedge clk) begin
        if (bus0.out_valid === 1'b1) begin
            got_q.push_back('{int'(bus0.out_data), int'(bus2.out_data), bus2.out_valid, cycle});
        end
    end

    function automatic int clip8(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    // Reference: pixels of the current frame in raster order; a result exists
    // for every pixel whose K x K neighbourhood above-left lies inside the frame.
    function automatic void model_accept(input bit sof, input int d);
        int n;
        int r;
        int c;
        int acc;
        if (sof) frame_q.delete();
        n = frame_q.size();
        frame_q.push_back(d);
        r = n / IMG;
        c = n % IMG;
        if (r >= K - 1 && c >= K - 1) begin
            acc = 0;
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K; j++) begin
                    acc += frame_q[(r - K + 1 + i) * IMG + (c - K + 1 + j)] * kern_m[i * K + j];
                end
            end
            exp_q.push_back('{clip8(acc), clip8(acc >>> 2)});
        end
    endfunction

    task automatic send(input bit v, input bit s, input int d);
        bus0.in_valid = v;
        bus0.in_sof   = s;
        bus0.in_data  = 8'(d);
        if (v) model_accept(s, d);
        @(posedge clk);
        #1;
        bus0.in_valid = 1'b0;
        bus0.in_sof   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) send(1'b0, 1'b0, 0);
    endtask

    task automatic write_coef(input int a, input int v);
        bus0.k_we   = 1'b1;
        bus0.k_addr = 4'(a);
        bus0.k_data = 8'(v);
        @(posedge clk);
        #1;
        bus0.k_we = 1'b0;
        kern_m[a] = v;
    endtask

    // mode 0: centre/other constant, mode 1: random small coefficients
    task automatic load_kernel(input int mode, input int centre, input int other);
        for (int a = 0; a < KK; a++) begin
            if (mode == 1) write_coef(a, int'($urandom_range(0, 6)) - 3);
            else write_coef(a, (a == KK / 2) ? centre : other);
        end
    endtask

    // mode 0: base+i, mode 1: constant base, mode 2: random
    task automatic run_frame(input int n, input bit sof, input bit gaps, input int mode, input int base);
        for (int i = 0; i < n; i++) begin
            int d;
            if (gaps && $urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
            case (mode)
                0:       d = base + i;
                1:       d = base;
                default: d = int'($urandom_range(0, 63)) - 32;
            endcase
            if (i == 12) p12_edge = cycle + 1;
            send(1'b1, sof && (i == 0), d);
        end
    endtask

    task automatic test_reset;
        reset_n       = 1'b1;
        bus0.k_we     = 1'b0;
        bus0.k_addr   = '0;
        bus0.k_data   = '0;
        bus0.in_valid = 1'b0;
        bus0.in_sof   = 1'b0;
        bus0.in_data  = '0;
        for (int a = 0; a < KK; a++) kern_m[a] = 0;
        #3 reset_n = 1'b0;
        #1;
        n_checks++;
        if (bus0.out_valid !== 1'b0 || bus2.out_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_valid: got %b/%b, expected 0/0", bus0.out_valid, bus2.out_valid);
        end
        n_checks++;
        if (bus0.out_data !== 8'sd0 || bus2.out_data !== 8'sd0) begin
            n_fail++;
            $display("[TB] FAIL reset_data: got %0d/%0d, expected 0/0", bus0.out_data, bus2.out_data);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        idle(2);
    endtask

    task automatic test_center;
        load_kernel(0, 1, 0);
        run_frame(25, 1'b1, 1'b0, 0, 0);
        idle(6);
        n_checks++;
        if (got_q.size() !== exp_q.size() || got_q.size() !== 9) begin
            n_fail++;
            $display("[TB] FAIL center_count: got %0d outputs, expected 9 (model %0d)", got_q.size(), exp_q.size());
        end
        if (got_q.size() >= 9) begin
            n_checks++;
            if (got_q[0].v0 !== 6 || got_q[8].v0 !== 18) begin
                n_fail++;
                $display("[TB] FAIL center_ends: got %0d..%0d, expected 6..18", got_q[0].v0, got_q[8].v0);
            end
            n_checks++;
            if (got_q[0].cyc !== p12_edge + 3) begin
                n_fail++;
                $display("[TB] FAIL center_latency: got edge %0d, expected edge %0d", got_q[0].cyc, p12_edge + 3);
            end
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i].v0 !== exp_q[i].e0 || got_q[i].v2 !== exp_q[i].e2 || got_q[i].ok2 !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL center_out[%0d]: got %0d/%0d, expected %0d/%0d", i, got_q[i].v0, got_q[i].v2, exp_q[i].e0, exp_q[i].e2);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_saturation;
        load_kernel(0, 1, 1);
        run_frame(25, 1'b1, 1'b0, 1, 100);
        run_frame(25, 1'b1, 1'b0, 1, -100);
        idle(6);
        n_checks++;
        if (got_q.size() !== exp_q.size() || got_q.size() !== 18) begin
            n_fail++;
            $display("[TB] FAIL sat_count: got %0d outputs, expected 18 (model %0d)", got_q.size(), exp_q.size());
        end
        if (got_q.size() >= 18) begin
            n_checks++;
            if (got_q[0].v0 !== 127 || got_q[17].v0 !== -128) begin
                n_fail++;
                $display("[TB] FAIL sat_limits: got %0d/%0d, expected 127/-128", got_q[0].v0, got_q[17].v0);
            end
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i].v0 !== exp_q[i].e0 || got_q[i].v2 !== exp_q[i].e2 || got_q[i].ok2 !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL sat_out[%0d]: got %0d/%0d, expected %0d/%0d", i, got_q[i].v0, got_q[i].v2, exp_q[i].e0, exp_q[i].e2);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_frac;
        run_frame(25, 1'b1, 1'b0, 1, 4);
        idle(6);
        n_checks++;
        if (got_q.size() !== 9) begin
            n_fail++;
            $display("[TB] FAIL frac_count: got %0d outputs, expected 9", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i].v2 !== 9 || got_q[i].v0 !== exp_q[i].e0 || got_q[i].ok2 !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL frac_out[%0d]: got %0d/%0d, expected %0d/9", i, got_q[i].v0, got_q[i].v2, exp_q[i].e0);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_gaps;
        load_kernel(0, 1, 0);
        run_frame(25, 1'b1, 1'b1, 0, 0);
        idle(6);
        n_checks++;
        if (got_q.size() !== 9 || exp_q.size() !== 9) begin
            n_fail++;
            $display("[TB] FAIL gaps_count: got %0d outputs, expected 9", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i].v0 !== exp_q[i].e0 || got_q[i].v2 !== exp_q[i].e2 || got_q[i].ok2 !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL gaps_out[%0d]: got %0d/%0d, expected %0d/%0d", i, got_q[i].v0, got_q[i].v2, exp_q[i].e0, exp_q[i].e2);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_back_to_back;
        load_kernel(1, 0, 0);
        run_frame(25, 1'b1, 1'b0, 2, 0);
        run_frame(30, 1'b1, 1'b1, 2, 0);
        run_frame(25, 1'b1, 1'b0, 2, 0);
        idle(6);
        n_checks++;
        if (got_q.size() !== exp_q.size() || got_q.size() !== 30) begin
            n_fail++;
            $display("[TB] FAIL b2b_count: got %0d outputs, expected 30 (model %0d)", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i].v0 !== exp_q[i].e0 || got_q[i].v2 !== exp_q[i].e2 || got_q[i].ok2 !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL b2b_out[%0d]: got %0d/%0d, expected %0d/%0d", i, got_q[i].v0, got_q[i].v2, exp_q[i].e0, exp_q[i].e2);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_kernel_rewrite;
        load_kernel(0, 2, 0);
        run_frame(25, 1'b1, 1'b0, 0, 0);
        run_frame(7, 1'b1, 1'b0, 0, 100);
        run_frame(25, 1'b1, 1'b0, 0, 0);
        idle(6);
        n_checks++;
        if (got_q.size() !== exp_q.size() || got_q.size() !== 18) begin
            n_fail++;
            $display("[TB] FAIL rewrite_count: got %0d outputs, expected 18 (model %0d)", got_q.size(), exp_q.size());
        end
        if (got_q.size() >= 18) begin
            n_checks++;
            if (got_q[0].v0 !== 12 || got_q[8].v0 !== 36 || got_q[9].v0 !== 12) begin
                n_fail++;
                $display("[TB] FAIL rewrite_ends: got %0d,%0d,%0d, expected 12,36,12", got_q[0].v0, got_q[8].v0, got_q[9].v0);
            end
            n_checks++;
            if (got_q[9].cyc !== p12_edge + 3) begin
                n_fail++;
                $display("[TB] FAIL sof_restart: got edge %0d, expected edge %0d", got_q[9].cyc, p12_edge + 3);
            end
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i].v0 !== exp_q[i].e0 || got_q[i].v2 !== exp_q[i].e2 || got_q[i].ok2 !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL rewrite_out[%0d]: got %0d/%0d, expected %0d/%0d", i, got_q[i].v0, got_q[i].v2, exp_q[i].e0, exp_q[i].e2);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_midstream;
        load_kernel(0, 1, 0);
        run_frame(17, 1'b1, 1'b0, 0, 0);
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (bus0.out_valid !== 1'b0 || bus2.out_valid !== 1'b0 || bus0.out_data !== 8'sd0 || bus2.out_data !== 8'sd0) begin
            n_fail++;
            $display("[TB] FAIL midreset_outputs: got v=%b/%b d=%0d/%0d, expected v=0/0 d=0/0", bus0.out_valid, bus2.out_valid, bus0.out_data, bus2.out_data);
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i].v0 !== exp_q[i].e0 || got_q[i].v2 !== exp_q[i].e2) begin
                n_fail++;
                $display("[TB] FAIL midreset_pre[%0d]: got %0d/%0d, expected %0d/%0d", i, got_q[i].v0, got_q[i].v2, exp_q[i].e0, exp_q[i].e2);
            end
        end
        got_q.delete();
        exp_q.delete();
        frame_q.delete();
        for (int a = 0; a < KK; a++) kern_m[a] = 0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        idle(5);
        n_checks++;
        if (got_q.size() !== 0) begin
            n_fail++;
            $display("[TB] FAIL midreset_drop: got %0d outputs, expected 0", got_q.size());
        end
        run_frame(25, 1'b0, 1'b0, 2, 0);
        idle(6);
        n_checks++;
        if (got_q.size() !== 9 || exp_q.size() !== 9) begin
            n_fail++;
            $display("[TB] FAIL midreset_refill: got %0d outputs, expected 9", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i].v0 !== exp_q[i].e0 || got_q[i].v2 !== exp_q[i].e2 || got_q[i].ok2 !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL midreset_out[%0d]: got %0d/%0d, expected %0d/%0d", i, got_q[i].v0, got_q[i].v2, exp_q[i].e0, exp_q[i].e2);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_center();
        test_saturation();
        test_frac();
        test_gaps();
        test_back_to_back();
        test_kernel_rewrite();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
